// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: raster-order VRAM reads, sync generation and data realignment.
// Optional build macro VGA_BORDER_TEST_EN forces a white one-pixel frame around the visible area.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              clk25M,
    input  logic              reset,
    output logic [ADDR_W-1:0] vram_raddr,
    output logic              vram_ren,
    input  logic [11:0]       vram_rdata,
    output logic [3:0]        vgaR,
    output logic [3:0]        vgaG,
    output logic [3:0]        vgaB,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [9:0]        hpos,
    output logic [9:0]        vpos,
    output logic              frame_start
);

    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIPE_D = RD_LAT + 1;

    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       first;
        logic [9:0] x;
        logic [9:0] y;
    } tag_t;

    localparam tag_t TAG_BLANK = '{hs: 1'b1, vs: 1'b1, act: 1'b0, first: 1'b0, x: '0, y: '0};

    logic [9:0]        hcnt;
    logic [9:0]        vcnt;
    logic [ADDR_W-1:0] raddr;
    logic              h_end;
    logic              v_end;
    logic              active;
    tag_t              tag_in;
    tag_t              tag_out;
    tag_t [PIPE_D-1:0] pipe;
    logic [11:0]       pix;

    assign h_end  = (hcnt == H_LAST);
    assign v_end  = (vcnt == V_LAST);
    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);

    // Stage 0: free-running raster counters and the incremental read address.
    // NOTE: every sequential block uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk25M or negedge reset) begin
        if (!reset) begin
            hcnt  <= '0;
            vcnt  <= '0;
            raddr <= '0;
        end else begin
            hcnt <= h_end ? '0 : hcnt + 10'd1;
            if (h_end) begin
                vcnt <= v_end ? '0 : vcnt + 10'd1;
            end
            if (h_end && v_end) begin
                raddr <= '0;
            end else if (active) begin
                raddr <= raddr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk25M or negedge reset) begin
        if (!reset) begin
            vram_ren   <= 1'b0;
            vram_raddr <= '0;
        end else begin
            vram_ren <= active;
            if (active) begin
                vram_raddr <= raddr;
            end
        end
    end

    assign tag_in = '{
        hs:    !((hcnt >= HS_ON) && (hcnt < HS_OFF)),
        vs:    !((vcnt >= VS_ON) && (vcnt < VS_OFF)),
        act:   active,
        first: (hcnt == '0) && (vcnt == '0),
        x:     hcnt,
        y:     vcnt
    };

    // Timing tags ride alongside the read so they meet the returning data at the output stage.
    // NOTE: this pipe is a handful of flops, not a RAM, so flushing it on reset is cheap and keeps sync idle.
    always_ff @(posedge clk25M or negedge reset) begin
        if (!reset) begin
            pipe <= {PIPE_D{TAG_BLANK}};
        end else begin
            pipe <= {pipe[PIPE_D-2:0], tag_in};
        end
    end

    assign tag_out = pipe[PIPE_D-1];

`ifdef VGA_BORDER_TEST_EN
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);
    logic border;
    assign border = (tag_out.x == '0) || (tag_out.x == X_MAX) ||
                    (tag_out.y == '0) || (tag_out.y == Y_MAX);
    assign pix    = border ? 12'hFFF : vram_rdata;
`else
    assign pix = vram_rdata;
`endif

    always_ff @(posedge clk25M or negedge reset) begin
        if (!reset) begin
            {vgaR, vgaG, vgaB} <= 12'h000;
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            de                 <= 1'b0;
            hpos               <= '0;
            vpos               <= '0;
            frame_start        <= 1'b0;
        end else begin
            {vgaR, vgaG, vgaB} <= tag_out.act ? pix : 12'h000;
            hsync              <= tag_out.hs;
            vsync              <= tag_out.vs;
            de                 <= tag_out.act;
            hpos               <= tag_out.x;
            vpos               <= tag_out.y;
            frame_start        <= tag_out.first;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance for the early-frame timing and a shrunken
// instance that runs whole frames; both are compared against a raster-arithmetic model.
module tb_vga_scanout;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, lat;
    } geom_t;

    typedef struct {
        logic [11:0] rgb;
        logic        hs, vs, de, fs, ren;
        logic [9:0]  x, y;
        logic [18:0] addr;
    } exp_t;

    localparam int F_LAT = 2;
    localparam int S_LAT = 3;
    localparam int S_FRAME = 25 * 13;
    localparam int S_LAST_ADDR = 16 * 8 - 1;

    logic clk25M = 1'b0;
    always #20 clk25M = ~clk25M;

    logic        reset_f = 1'b0;
    logic        reset_s = 1'b0;
    int          mode_f = 0;
    int          mode_s = 1;
    logic [11:0] seed_mul = 12'h001;
    logic [11:0] seed_add = 12'h000;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_addr_f = 0;
    int          last_addr_s = 0;

    logic [18:0] f_raddr, s_raddr;
    logic        f_ren, s_ren;
    logic [11:0] f_rdata, s_rdata;
    logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b;
    logic        f_hs, f_vs, f_de, f_fs, s_hs, s_vs, s_de, s_fs;
    logic [9:0]  f_hpos, f_vpos, s_hpos, s_vpos;

    vga_scanout #(.RD_LAT(F_LAT)) dut_f (
        .clk25M(clk25M), .reset(reset_f),
        .vram_raddr(f_raddr), .vram_ren(f_ren), .vram_rdata(f_rdata),
        .vgaR(f_r), .vgaG(f_g), .vgaB(f_b),
        .hsync(f_hs), .vsync(f_vs), .de(f_de),
        .hpos(f_hpos), .vpos(f_vpos), .frame_start(f_fs)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .RD_LAT(S_LAT)
    ) dut_s (
        .clk25M(clk25M), .reset(reset_s),
        .vram_raddr(s_raddr), .vram_ren(s_ren), .vram_rdata(s_rdata),
        .vgaR(s_r), .vgaG(s_g), .vgaB(s_b),
        .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .hpos(s_hpos), .vpos(s_vpos), .frame_start(s_fs)
    );

    function automatic geom_t geom(input bit sm);
        geom_t g;
        if (sm) g = '{ha: 16, hf: 2, hs: 4, hb: 3, va: 8, vf: 1, vs: 2, vb: 2, lat: S_LAT};
        else    g = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, lat: F_LAT};
        return g;
    endfunction

    // VRAM contents as a function of address for each data pattern.
    function automatic logic [11:0] memv(input int a, input int mode);
        logic [31:0] prod;
        prod = 32'(a) * 32'(seed_mul) + 32'(seed_add);
        case (mode)
            0:       return 12'(a);
            1:       return 12'hFFF;
            2:       return prod[11:0];
            default: return 12'h000;
        endcase
    endfunction

    // Behavioural VRAMs with a fixed read latency; unread slots return noise.
    logic [11:0] rq_f [4];
    logic [11:0] rq_s [4];
    always @(posedge clk25M) begin
        for (int i = 3; i > 0; i--) begin
            rq_f[i] <= rq_f[i-1];
            rq_s[i] <= rq_s[i-1];
        end
        rq_f[0] <= (f_ren || mode_f == 1) ? memv(int'(f_raddr), mode_f) : 12'($urandom);
        rq_s[0] <= (s_ren || mode_s == 1) ? memv(int'(s_raddr), mode_s) : 12'($urandom);
    end
    assign f_rdata = rq_f[F_LAT-1];
    assign s_rdata = rq_s[S_LAT-1];

    // Expected outputs k rising edges after reset release, from raster arithmetic.
    function automatic exp_t model(input geom_t g, input int k, input int mode);
        exp_t e;
        int   ht, vt, n, m, h, v;
        logic border;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, ren: 1'b0,
              x: 10'd0, y: 10'd0, addr: 19'd0};
        n = k - (g.lat + 2);
        if (n >= 0) begin
            h = n % ht;
            v = (n / ht) % vt;
            e.de = (h < g.ha) && (v < g.va);
            e.x  = 10'(h);
            e.y  = 10'(v);
            e.fs = (h == 0) && (v == 0);
            e.hs = !((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs));
            e.vs = !((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs));
            border = 1'b0;
`ifdef VGA_BORDER_TEST_EN
            border = (h == 0) || (h == g.ha - 1) || (v == 0) || (v == g.va - 1);
`endif
            if (e.de) e.rgb = border ? 12'hFFF : memv(v * g.ha + h, mode);
        end
        m = k - 1;
        if (m >= 0) begin
            h = m % ht;
            v = (m / ht) % vt;
            e.ren  = (h < g.ha) && (v < g.va);
            e.addr = 19'(v * g.ha + h);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk25M);
        @(negedge clk25M);
    endtask

    task automatic check_reset(input bit sm);
        string p;
        p = sm ? "S" : "F";
        check({p, ".rst_ren"},   sm ? s_ren : f_ren, 0);
        check({p, ".rst_raddr"}, sm ? s_raddr : f_raddr, 0);
        check({p, ".rst_rgb"},   sm ? {s_r, s_g, s_b} : {f_r, f_g, f_b}, 0);
        check({p, ".rst_hsync"}, sm ? s_hs : f_hs, 1);
        check({p, ".rst_vsync"}, sm ? s_vs : f_vs, 1);
        check({p, ".rst_de"},    sm ? s_de : f_de, 0);
        check({p, ".rst_hpos"},  sm ? s_hpos : f_hpos, 0);
        check({p, ".rst_vpos"},  sm ? s_vpos : f_vpos, 0);
        check({p, ".rst_fs"},    sm ? s_fs : f_fs, 0);
    endtask

    task automatic check_cycle(input bit sm, input int k);
        exp_t e;
        string p;
        int la;
        e  = model(geom(sm), k, sm ? mode_s : mode_f);
        p  = sm ? "S" : "F";
        la = sm ? last_addr_s : last_addr_f;
        if (e.ren) la = int'(e.addr);
        if (sm) last_addr_s = la; else last_addr_f = la;
        check({p, ".rgb"},   sm ? {s_r, s_g, s_b} : {f_r, f_g, f_b}, e.rgb);
        check({p, ".hsync"}, sm ? s_hs : f_hs, e.hs);
        check({p, ".vsync"}, sm ? s_vs : f_vs, e.vs);
        check({p, ".de"},    sm ? s_de : f_de, e.de);
        check({p, ".fs"},    sm ? s_fs : f_fs, e.fs);
        check({p, ".ren"},   sm ? s_ren : f_ren, e.ren);
        check({p, ".raddr"}, sm ? s_raddr : f_raddr, la);
        if (e.de) begin
            check({p, ".hpos"}, sm ? s_hpos : f_hpos, e.x);
            check({p, ".vpos"}, sm ? s_vpos : f_vpos, e.y);
        end
    endtask

    task automatic run_full(input int n);
        last_addr_f = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            check_cycle(1'b0, k);
            if (k == 1) check("F.first_raddr", f_raddr, 0);
            if (k == 3) check("F.fs_early", f_fs, 0);
            if (k == 4) begin
                check("F.first_fs", f_fs, 1);
                check("F.first_de", f_de, 1);
            end
            if (k == 659)  check("F.hs_before", f_hs, 1);
            if (k == 660)  check("F.hs_fall", f_hs, 0);
            if (k == 755)  check("F.hs_last_low", f_hs, 0);
            if (k == 756)  check("F.hs_rise", f_hs, 1);
            if (k == 1460) check("F.hs_fall2", f_hs, 0);
            if (k == 1606) begin
                check("F.raddr_5_2", f_raddr, 1285);
                check("F.ren_5_2", f_ren, 1);
            end
            if (k == 1609) begin
                check("F.rgb_5_2", {f_r, f_g, f_b}, 12'h505);
                check("F.hpos_5_2", f_hpos, 5);
                check("F.vpos_5_2", f_vpos, 2);
            end
        end
    endtask

    task automatic run_small(input int n);
        bit have_fs, have_prev;
        int last_fs;
        logic [18:0] prev;
        have_fs = 0; have_prev = 0; last_fs = 0; prev = '0;
        last_addr_s = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            check_cycle(1'b1, k);
            if (s_fs) begin
                if (have_fs) check("S.fs_period", k - last_fs, S_FRAME);
                last_fs = k;
                have_fs = 1;
            end
            if (s_ren) begin
                if (have_prev && s_raddr == 0) check("S.wrap_prev", prev, S_LAST_ADDR);
                prev = s_raddr;
                have_prev = 1;
            end
        end
    endtask

    initial begin
        seed_mul = 12'($urandom) | 12'h001;
        seed_add = 12'($urandom);
        repeat (3) @(posedge clk25M);
        @(negedge clk25M);
        check_reset(1'b0);
        check_reset(1'b1);

        // Full-size: first lines with the address-pattern VRAM.
        reset_f = 1'b1;
        run_full(1900);

        // Asynchronous reset while the counters sit at (300,2).
        reset_f = 1'b0;
        #1;
        check_reset(1'b0);
        repeat (3) @(posedge clk25M);
        @(negedge clk25M);
        check_reset(1'b0);
        reset_f = 1'b1;
        run_full(40);
        reset_f = 1'b0;

        // Shrunken raster: constant white VRAM over three frames.
        reset_s = 1'b1;
        run_small(3 * S_FRAME + 10);

        // Random VRAM contents, then a mid-frame reset and restart.
        reset_s = 1'b0;
        mode_s  = 2;
        step();
        check_reset(1'b1);
        reset_s = 1'b1;
        run_small(5 * 25 + 9);
        reset_s = 1'b0;
        #1;
        check_reset(1'b1);
        repeat (3) @(posedge clk25M);
        @(negedge clk25M);
        check_reset(1'b1);
        reset_s = 1'b1;
        run_small(2 * S_FRAME + 10);

        // All-zero VRAM: only the optional border can light pixels.
        reset_s = 1'b0;
        mode_s  = 3;
        step();
        reset_s = 1'b1;
        run_small(S_FRAME + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
